// File: rtl/codifica_hamming_fila.sv
// Hamming(15,11) encoder feeding a small codeword FIFO.
// Latency: 1 cycle from the acceptance edge to out_valid when the FIFO is empty.
// Backpressure: in_ready drops when the FIFO is full; a same-cycle pop does not reopen it.
//
// Parameters:
//   PROFUNDIDADE  FIFO depth in codewords; a power of two from 2 to 16.
//
// Optional build macro:
//   ERR_INJ_EN    Adds the inj_pos port. A nonzero inj_pos at acceptance flips
//                 codeword bit inj_pos-1 before the codeword is stored, so the
//                 downstream corrector can be exercised with single-bit errors.
//
// Ports:
//   clk        single clock; all state changes on the rising edge
//   rst_n      asynchronous active-low reset; empties the FIFO
//   in_valid   dado holds a word to encode
//   in_ready   the FIFO has room for a word this cycle
//   dado       11-bit data word d10..d0
//   inj_pos    error-injection position (ERR_INJ_EN builds only)
//   out_valid  codigo holds a valid codeword (FIFO not empty)
//   out_ready  downstream consumes codigo this cycle
//   codigo     codeword at the FIFO head; all zeros while the FIFO is empty
//   nivel      current FIFO occupancy

module codifica_hamming_fila #(
  parameter int PROFUNDIDADE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [10:0] dado,
`ifdef ERR_INJ_EN
  input  logic [3:0]  inj_pos,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [14:0] codigo,
  output logic [4:0]  nivel
);

  // Pointer width; depth is a power of two, so natural pointer overflow
  // is exactly the modulo-PROFUNDIDADE wrap.
  localparam int PW = $clog2(PROFUNDIDADE);
  localparam logic [4:0] PROF_NIVEL = 5'(PROFUNDIDADE);

  // Codeword bit k is Hamming position k+1. Parity sits at the
  // power-of-two positions (bits 0, 1, 3, 7); data fills the rest in order.
  function automatic logic [14:0] hamming_enc(input logic [10:0] d);
    logic [14:0] c;
    c        = '0;
    c[2]     = d[0];
    c[6:4]   = d[3:1];
    c[14:8]  = d[10:4];
    c[0]     = c[2] ^ c[4] ^ c[6] ^ c[8]  ^ c[10] ^ c[12] ^ c[14];
    c[1]     = c[2] ^ c[5] ^ c[6] ^ c[9]  ^ c[10] ^ c[13] ^ c[14];
    c[3]     = c[4] ^ c[5] ^ c[6] ^ c[11] ^ c[12] ^ c[13] ^ c[14];
    c[7]     = ^c[14:8];
    return c;
  endfunction

  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [4:0]    nivel_q, nivel_d;
  logic [14:0]   mem_q [PROFUNDIDADE];

  logic          push;
  logic          pop;
  logic [14:0]   erro_mask;
  logic [14:0]   palavra;

  // Flow control comes from registered occupancy only, so a full FIFO
  // refuses a push even when the head is being popped in the same cycle.
  assign in_ready  = (nivel_q != PROF_NIVEL);
  assign out_valid = (nivel_q != 5'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign nivel     = nivel_q;

  // Storage is not reset, so the head is masked while empty to keep
  // stale or uninitialised codewords off the output.
  assign codigo    = out_valid ? mem_q[rd_q] : 15'h0000;

`ifdef ERR_INJ_EN
  // inj_pos == 0 means no injection; otherwise it names Hamming position
  // inj_pos, i.e. codeword bit inj_pos-1.
  always_comb begin
    erro_mask = '0;
    if (inj_pos != 4'd0) begin
      erro_mask = 15'b1 << (inj_pos - 4'd1);
    end
  end
`else
  assign erro_mask = '0;
`endif

  assign palavra = hamming_enc(dado) ^ erro_mask;

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    nivel_d = nivel_q;
    if (push) begin
      wr_d = wr_q + 1'b1;
    end
    if (pop) begin
      rd_d = rd_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   nivel_d = nivel_q + 5'd1;
      2'b01:   nivel_d = nivel_q - 5'd1;
      default: nivel_d = nivel_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      nivel_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      nivel_q <= nivel_d;
    end
  end

  // Data array: written at the acceptance edge, no reset needed because
  // occupancy alone decides which entries are visible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q] <= palavra;
    end
  end

endmodule

// File: tb/tb_codifica_hamming_fila.sv
module tb_codifica_hamming_fila;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] dado;
`ifdef ERR_INJ_EN
  logic [3:0]  inj_pos;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [14:0] codigo;
  logic [4:0]  nivel;

  int n_total;
  int n_pass;

  logic [14:0] exp_q[$];
  logic [10:0] fill_w [5];

  codifica_hamming_fila #(.PROFUNDIDADE(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dado      (dado),
`ifdef ERR_INJ_EN
    .inj_pos   (inj_pos),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .codigo    (codigo),
    .nivel     (nivel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference encoder built from the positional Hamming definition:
  // data fills non-power-of-two positions, parity bit 2^b covers every
  // position whose index has bit b set.
  function automatic logic [14:0] ref_enc(input logic [10:0] d);
    logic [14:0] c;
    logic        x;
    int          j;
    c = '0;
    j = 0;
    for (int p = 1; p <= 15; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p-1] = d[j];
        j++;
      end
    end
    for (int b = 0; b < 4; b++) begin
      x = 1'b0;
      for (int p = 1; p <= 15; p++) begin
        if ((((p >> b) & 1) == 1) && (p != (1 << b))) x = x ^ c[p-1];
      end
      c[(1 << b) - 1] = x;
    end
    return c;
  endfunction

`ifdef ERR_INJ_EN
  // Single-error corrector: the syndrome is the XOR of the positions of all
  // set bits; a nonzero syndrome names the flipped position.
  function automatic logic [10:0] ref_dec(input logic [14:0] cw);
    logic [14:0] c;
    logic [3:0]  s;
    logic [10:0] d;
    int          j;
    c = cw;
    s = '0;
    for (int p = 1; p <= 15; p++) begin
      if (c[p-1]) s = s ^ 4'(p);
    end
    if (s != 4'd0) c[s-4'd1] = ~c[s-4'd1];
    d = '0;
    j = 0;
    for (int p = 1; p <= 15; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[j] = c[p-1];
        j++;
      end
    end
    return d;
  endfunction
`endif

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_total  = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    dado     = '0;
    out_ready = 1'b0;
`ifdef ERR_INJ_EN
    inj_pos  = 4'd0;
`endif
    fill_w[0] = 11'h123;
    fill_w[1] = 11'h456;
    fill_w[2] = 11'h789;
    fill_w[3] = 11'h7AB;
    fill_w[4] = 11'h0CD;

    // Reset state
    step();
    step();
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_in_ready",  16'(in_ready),  16'd1);
    chk("rst_nivel",     16'(nivel),     16'd0);
    chk("rst_codigo",    16'(codigo),    16'h0000);

    // First word at the first edge after reset release, 1-cycle latency
    rst_n    = 1'b1;
    in_valid = 1'b1;
    dado     = 11'h000;
    step();
    in_valid = 1'b0;
    chk("zero_out_valid", 16'(out_valid), 16'd1);
    chk("zero_codigo",    16'(codigo),    16'h0000);
    chk("zero_nivel",     16'(nivel),     16'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("zero_popped_valid", 16'(out_valid), 16'd0);

    // Hand-computed codewords
    in_valid = 1'b1; dado = 11'h001;
    step();
    in_valid = 1'b0;
    chk("enc_001", 16'(codigo), 16'h0007);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    in_valid = 1'b1; dado = 11'h7FF;
    step();
    in_valid = 1'b0;
    chk("enc_7ff", 16'(codigo), 16'h7FFF);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    in_valid = 1'b1; dado = 11'h555;
    step();
    in_valid = 1'b0;
    chk("enc_555", 16'(codigo), 16'h552D);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("empty_codigo", 16'(codigo), 16'h0000);

    // Fill with downstream stalled: 4 accepted, 5th held off
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dado = fill_w[i];
      step();
    end
    dado = fill_w[4];
    chk("full_nivel",    16'(nivel),    16'd4);
    chk("full_in_ready", 16'(in_ready), 16'd0);
    step();
    chk("full_hold_nivel",  16'(nivel),     16'd4);
    chk("full_hold_valid",  16'(out_valid), 16'd1);
    chk("full_hold_codigo", 16'(codigo),    16'(ref_enc(fill_w[0])));

    // Drain: the first pop does not make room in the same cycle
    out_ready = 1'b1;
    step();
    chk("drain1_codigo",   16'(codigo),   16'(ref_enc(fill_w[1])));
    chk("drain1_nivel",    16'(nivel),    16'd3);
    chk("drain1_in_ready", 16'(in_ready), 16'd1);
    step();
    in_valid = 1'b0;
    chk("drain2_codigo", 16'(codigo), 16'(ref_enc(fill_w[2])));
    chk("drain2_nivel",  16'(nivel),  16'd3);
    step();
    chk("drain3_codigo", 16'(codigo), 16'(ref_enc(fill_w[3])));
    step();
    chk("drain4_codigo", 16'(codigo), 16'(ref_enc(fill_w[4])));
    chk("drain4_nivel",  16'(nivel),  16'd1);
    step();
    chk("drain5_valid",  16'(out_valid), 16'd0);
    out_ready = 1'b0;

    // Prime two entries, then 20 cycles of simultaneous push and pop
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      dado = 11'(i * 37 + 5);
      exp_q.push_back(ref_enc(dado));
      step();
    end
    chk("stream_prime_nivel", 16'(nivel), 16'd2);
    out_ready = 1'b1;
    for (int i = 2; i < 22; i++) begin
      dado = 11'(i * 37 + 5);
      chk("stream_codigo", 16'(codigo), 16'(exp_q[0]));
      step();
      void'(exp_q.pop_front());
      exp_q.push_back(ref_enc(dado));
      chk("stream_nivel", 16'(nivel), 16'd2);
    end
    out_ready = 1'b0;
    dado = 11'h3C3;
    step();
    in_valid = 1'b0;
    chk("pre_reset_nivel", 16'(nivel), 16'd3);

    // Asynchronous reset mid-operation
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 16'(out_valid), 16'd0);
    chk("arst_nivel",     16'(nivel),     16'd0);
    chk("arst_codigo",    16'(codigo),    16'h0000);
    chk("arst_in_ready",  16'(in_ready),  16'd1);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_valid",  16'(out_valid), 16'd0);
    chk("post_rst_codigo", 16'(codigo),    16'h0000);
    in_valid = 1'b1; dado = 11'h555;
    step();
    in_valid = 1'b0;
    chk("post_rst_enc", 16'(codigo), 16'h552D);
    chk("post_rst_nivel", 16'(nivel), 16'd1);
    out_ready = 1'b1; step(); out_ready = 1'b0;

`ifdef ERR_INJ_EN
    in_valid = 1'b1; dado = 11'h001; inj_pos = 4'd3;
    step();
    in_valid = 1'b0; inj_pos = 4'd0;
    chk("inj_codigo",  16'(codigo), 16'h0003);
    chk("inj_correct", 16'(ref_dec(codigo)), 16'h0001);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    in_valid = 1'b1; dado = 11'h001; inj_pos = 4'd0;
    step();
    in_valid = 1'b0;
    chk("inj_none", 16'(codigo), 16'h0007);
    out_ready = 1'b1; step(); out_ready = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
